// File: rtl/bp_me_host_beat_splitter.sv
// Splits multi-beat BedRock mem commands into single-beat host commands and reassembles one multi-beat response.
// Define BP_ME_BEAT_SPLITTER_CHECK_EN to enable sticky protocol checking on err_o.
module bp_me_host_beat_splitter
    #(parameter int paddr_width_p = 40
    , parameter int beat_width_p  = 64
    , parameter int max_beats_p   = 8
    // Header layout, LSB first: size[2:0], addr[paddr_width_p-1:0], msg_type[3:0], payload[7:0]
    , localparam int mem_header_width_lp = 3 + paddr_width_p + 4 + 8
    )
    (input  logic                           clk_i
    , input  logic                           reset_i

    , input  logic [mem_header_width_lp-1:0] mem_cmd_header_i
    , input  logic                           mem_cmd_header_v_i
    , output logic                           mem_cmd_header_ready_and_o
    , input  logic                           mem_cmd_has_data_i
    , input  logic [beat_width_p-1:0]        mem_cmd_data_i
    , input  logic                           mem_cmd_data_v_i
    , output logic                           mem_cmd_data_ready_and_o
    , input  logic                           mem_cmd_data_last_i

    , output logic [mem_header_width_lp-1:0] mem_cmd_header_o
    , output logic                           mem_cmd_header_v_o
    , input  logic                           mem_cmd_header_ready_and_i
    , output logic                           mem_cmd_has_data_o
    , output logic [beat_width_p-1:0]        mem_cmd_data_o
    , output logic                           mem_cmd_data_v_o
    , input  logic                           mem_cmd_data_ready_and_i
    , output logic                           mem_cmd_data_last_o

    , input  logic [mem_header_width_lp-1:0] mem_resp_header_i
    , input  logic                           mem_resp_header_v_i
    , output logic                           mem_resp_header_ready_and_o
    , input  logic                           mem_resp_has_data_i
    , input  logic [beat_width_p-1:0]        mem_resp_data_i
    , input  logic                           mem_resp_data_v_i
    , output logic                           mem_resp_data_ready_and_o
    , input  logic                           mem_resp_data_last_i

    , output logic [mem_header_width_lp-1:0] mem_resp_header_o
    , output logic                           mem_resp_header_v_o
    , input  logic                           mem_resp_header_ready_and_i
    , output logic                           mem_resp_has_data_o
    , output logic [beat_width_p-1:0]        mem_resp_data_o
    , output logic                           mem_resp_data_v_o
    , input  logic                           mem_resp_data_ready_and_i
    , output logic                           mem_resp_data_last_o

    , output logic                           err_o
    );

    // state  | meaning
    // e_idle | waiting for an upstream command header
    // e_cmd  | issuing single-beat sub-command k to the host
    // e_resp | collecting host response k and forwarding it upstream
    typedef enum logic [1:0] {e_idle = 2'd0, e_cmd = 2'd1, e_resp = 2'd2} state_e;

    localparam int         cnt_width_lp    = $clog2(max_beats_p);
    localparam logic [2:0] max_beats_lg_lp = 3'($clog2(max_beats_p));
    localparam logic [2:0] beat_size_lp    = 3'($clog2(beat_width_p / 8));
    localparam int         addr_lsb_lp     = 3;

    state_e                         state_q, state_d;
    logic [cnt_width_lp-1:0]        k_q, k_d;
    logic                           hdr_sent_q, hdr_sent_d;
    logic [mem_header_width_lp-1:0] hdr_q, hdr_d;
    logic                           has_data_q, has_data_d;
    logic                           cmd_hdr_done_q, cmd_hdr_done_d;
    logic                           cmd_data_done_q, cmd_data_done_d;
    logic                           rhdr_done_q, rhdr_done_d;
    logic                           rdata_done_q, rdata_done_d;

    logic [2:0]                     size_lg, beats_lg, sub_size;
    logic [cnt_width_lp-1:0]        beat_mask, base_off, sub_off;
    logic [paddr_width_p-1:0]       sub_addr;
    logic [mem_header_width_lp-1:0] sub_hdr;
    logic                           last_beat;

    logic up_hdr_hs, up_data_hs, cmd_hdr_hs, cmd_data_hs, rhdr_hs, rdata_hs;
    logic cmd_done, resp_done;

    // Sub-command address wraps inside the aligned burst, like a critical-word-first fill.
    always_comb begin
        size_lg  = hdr_q[2:0];
        beats_lg = (size_lg > beat_size_lp) ? (size_lg - beat_size_lp) : 3'd0;
        if (beats_lg > max_beats_lg_lp)
            beats_lg = max_beats_lg_lp;
        sub_size  = (size_lg > beat_size_lp) ? beat_size_lp : size_lg;
        beat_mask = cnt_width_lp'((32'd1 << beats_lg) - 32'd1);
        base_off  = hdr_q[addr_lsb_lp+3 +: cnt_width_lp];
        sub_off   = (base_off & ~beat_mask) | ((base_off + k_q) & beat_mask);
        sub_addr  = hdr_q[addr_lsb_lp +: paddr_width_p];
        sub_addr[3 +: cnt_width_lp] = sub_off;
        sub_hdr   = hdr_q;
        sub_hdr[2:0] = sub_size;
        sub_hdr[addr_lsb_lp +: paddr_width_p] = sub_addr;
        last_beat = (k_q == beat_mask);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q         <= e_idle;
            k_q             <= '0;
            hdr_sent_q      <= 1'b0;
            hdr_q           <= '0;
            has_data_q      <= 1'b0;
            cmd_hdr_done_q  <= 1'b0;
            cmd_data_done_q <= 1'b0;
            rhdr_done_q     <= 1'b0;
            rdata_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            hdr_sent_q      <= hdr_sent_d;
            hdr_q           <= hdr_d;
            has_data_q      <= has_data_d;
            cmd_hdr_done_q  <= cmd_hdr_done_d;
            cmd_data_done_q <= cmd_data_done_d;
            rhdr_done_q     <= rhdr_done_d;
            rdata_done_q    <= rdata_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        hdr_sent_d      = hdr_sent_q;
        hdr_d           = hdr_q;
        has_data_d      = has_data_q;
        cmd_hdr_done_d  = cmd_hdr_done_q;
        cmd_data_done_d = cmd_data_done_q;
        rhdr_done_d     = rhdr_done_q;
        rdata_done_d    = rdata_done_q;
        unique case (state_q)
            e_idle: begin
                if (up_hdr_hs) begin
                    hdr_d      = mem_cmd_header_i;
                    has_data_d = mem_cmd_has_data_i;
                    k_d        = '0;
                    hdr_sent_d = 1'b0;
                    state_d    = e_cmd;
                end
            end
            e_cmd: begin
                cmd_hdr_done_d  = cmd_hdr_done_q | cmd_hdr_hs;
                cmd_data_done_d = cmd_data_done_q | cmd_data_hs;
                if (cmd_done) begin
                    cmd_hdr_done_d  = 1'b0;
                    cmd_data_done_d = 1'b0;
                    state_d         = e_resp;
                end
            end
            e_resp: begin
                rhdr_done_d  = rhdr_done_q | rhdr_hs;
                rdata_done_d = rdata_done_q | rdata_hs;
                if (mem_resp_header_v_o & mem_resp_header_ready_and_i)
                    hdr_sent_d = 1'b1;
                if (resp_done) begin
                    rhdr_done_d  = 1'b0;
                    rdata_done_d = 1'b0;
                    if (last_beat) begin
                        k_d        = '0;
                        hdr_sent_d = 1'b0;
                        state_d    = e_idle;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = e_cmd;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        mem_cmd_header_ready_and_o  = 1'b0;
        mem_cmd_data_ready_and_o    = 1'b0;
        mem_cmd_header_v_o          = 1'b0;
        mem_cmd_data_v_o            = 1'b0;
        mem_resp_header_ready_and_o = 1'b0;
        mem_resp_data_ready_and_o   = 1'b0;
        mem_resp_header_v_o         = 1'b0;
        mem_resp_data_v_o           = 1'b0;
        mem_cmd_header_o            = sub_hdr;
        mem_cmd_has_data_o          = has_data_q;
        mem_cmd_data_o              = mem_cmd_data_i;
        mem_cmd_data_last_o         = 1'b1;
        mem_resp_header_o           = hdr_q;
        mem_resp_has_data_o         = ~has_data_q;
        mem_resp_data_o             = mem_resp_data_i;
        mem_resp_data_last_o        = last_beat;
        unique case (state_q)
            e_idle: mem_cmd_header_ready_and_o = 1'b1;
            e_cmd: begin
                if (has_data_q) begin
                    // Each host handshake is remembered so the upstream beat pops exactly once.
                    mem_cmd_header_v_o       = mem_cmd_data_v_i & ~cmd_hdr_done_q;
                    mem_cmd_data_v_o         = mem_cmd_data_v_i & ~cmd_data_done_q;
                    mem_cmd_data_ready_and_o = (cmd_hdr_done_q | mem_cmd_header_ready_and_i)
                                             & (cmd_data_done_q | mem_cmd_data_ready_and_i);
                end else begin
                    mem_cmd_header_v_o = 1'b1;
                end
            end
            e_resp: begin
                mem_resp_header_v_o         = (k_q == '0) & mem_resp_header_v_i & ~hdr_sent_q;
                mem_resp_header_ready_and_o = ~rhdr_done_q & ((k_q != '0) | mem_resp_header_ready_and_i);
                if (!has_data_q) begin
                    mem_resp_data_v_o         = mem_resp_data_v_i & ~rdata_done_q;
                    mem_resp_data_ready_and_o = mem_resp_data_ready_and_i & ~rdata_done_q;
                end
            end
            default: ;
        endcase
        if (!reset_i) begin
            mem_cmd_header_ready_and_o  = 1'b0;
            mem_cmd_data_ready_and_o    = 1'b0;
            mem_cmd_header_v_o          = 1'b0;
            mem_cmd_data_v_o            = 1'b0;
            mem_resp_header_ready_and_o = 1'b0;
            mem_resp_data_ready_and_o   = 1'b0;
            mem_resp_header_v_o         = 1'b0;
            mem_resp_data_v_o           = 1'b0;
        end
    end

    assign up_hdr_hs   = mem_cmd_header_v_i & mem_cmd_header_ready_and_o;
    assign up_data_hs  = mem_cmd_data_v_i & mem_cmd_data_ready_and_o;
    assign cmd_hdr_hs  = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
    assign cmd_data_hs = mem_cmd_data_v_o & mem_cmd_data_ready_and_i;
    assign rhdr_hs     = mem_resp_header_v_i & mem_resp_header_ready_and_o;
    assign rdata_hs    = mem_resp_data_v_i & mem_resp_data_ready_and_o;
    assign cmd_done    = has_data_q ? up_data_hs : cmd_hdr_hs;
    assign resp_done   = (rhdr_done_q | rhdr_hs) & (has_data_q | rdata_done_q | rdata_hs);

    logic unused_sigs;
    assign unused_sigs = ^{mem_cmd_data_last_i, mem_resp_data_last_i, mem_resp_header_i, mem_resp_has_data_i};

`ifdef BP_ME_BEAT_SPLITTER_CHECK_EN
    logic err_q, err_d;
    logic chk_nolast, chk_addr, chk_uplast;

    assign chk_nolast = rdata_hs & ~mem_resp_data_last_i;
    assign chk_addr   = rhdr_hs & (mem_resp_header_i[addr_lsb_lp +: paddr_width_p] != sub_addr);
    assign chk_uplast = up_data_hs & mem_cmd_data_last_i & ~last_beat;
    assign err_d      = err_q | chk_nolast | chk_addr | chk_uplast;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    always_ff @(posedge clk_i) begin
        if (chk_nolast) $error("beat_splitter: host response beat %0d without last", k_q);
        if (chk_addr)   $error("beat_splitter: host response address mismatch on beat %0d", k_q);
        if (chk_uplast) $error("beat_splitter: upstream last on beat %0d", k_q);
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_host_beat_splitter.sv
// Directed bench for bp_me_host_beat_splitter: acts as both upstream master and nonsynth host.
module tb_bp_me_host_beat_splitter;

    localparam int HW = 3 + 40 + 4 + 8;

    logic clk_i, reset_i;
    logic [HW-1:0] mem_cmd_header_i, mem_cmd_header_o, mem_resp_header_i, mem_resp_header_o;
    logic mem_cmd_header_v_i, mem_cmd_header_ready_and_o, mem_cmd_has_data_i;
    logic [63:0] mem_cmd_data_i, mem_cmd_data_o, mem_resp_data_i, mem_resp_data_o;
    logic mem_cmd_data_v_i, mem_cmd_data_ready_and_o, mem_cmd_data_last_i;
    logic mem_cmd_header_v_o, mem_cmd_header_ready_and_i, mem_cmd_has_data_o;
    logic mem_cmd_data_v_o, mem_cmd_data_ready_and_i, mem_cmd_data_last_o;
    logic mem_resp_header_v_i, mem_resp_header_ready_and_o, mem_resp_has_data_i;
    logic mem_resp_data_v_i, mem_resp_data_ready_and_o, mem_resp_data_last_i;
    logic mem_resp_header_v_o, mem_resp_header_ready_and_i, mem_resp_has_data_o;
    logic mem_resp_data_v_o, mem_resp_data_ready_and_i, mem_resp_data_last_o;
    logic err_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [39:0] exp_a [8];
    logic exp_err;

    bp_me_host_beat_splitter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .mem_cmd_header_i(mem_cmd_header_i), .mem_cmd_header_v_i(mem_cmd_header_v_i),
        .mem_cmd_header_ready_and_o(mem_cmd_header_ready_and_o), .mem_cmd_has_data_i(mem_cmd_has_data_i),
        .mem_cmd_data_i(mem_cmd_data_i), .mem_cmd_data_v_i(mem_cmd_data_v_i),
        .mem_cmd_data_ready_and_o(mem_cmd_data_ready_and_o), .mem_cmd_data_last_i(mem_cmd_data_last_i),
        .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o),
        .mem_cmd_header_ready_and_i(mem_cmd_header_ready_and_i), .mem_cmd_has_data_o(mem_cmd_has_data_o),
        .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
        .mem_cmd_data_ready_and_i(mem_cmd_data_ready_and_i), .mem_cmd_data_last_o(mem_cmd_data_last_o),
        .mem_resp_header_i(mem_resp_header_i), .mem_resp_header_v_i(mem_resp_header_v_i),
        .mem_resp_header_ready_and_o(mem_resp_header_ready_and_o), .mem_resp_has_data_i(mem_resp_has_data_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
        .mem_resp_data_ready_and_o(mem_resp_data_ready_and_o), .mem_resp_data_last_i(mem_resp_data_last_i),
        .mem_resp_header_o(mem_resp_header_o), .mem_resp_header_v_o(mem_resp_header_v_o),
        .mem_resp_header_ready_and_i(mem_resp_header_ready_and_i), .mem_resp_has_data_o(mem_resp_has_data_o),
        .mem_resp_data_o(mem_resp_data_o), .mem_resp_data_v_o(mem_resp_data_v_o),
        .mem_resp_data_ready_and_i(mem_resp_data_ready_and_i), .mem_resp_data_last_o(mem_resp_data_last_o),
        .err_o(err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic wr, input logic [39:0] a, input logic [2:0] sz);
        return {8'h5A, (wr ? 4'h3 : 4'h2), a, sz};
    endfunction

    // One upstream transaction end to end; abort_at >= 0 pulls reset when that write beat is presented.
    task automatic run_txn(input logic wr, input logic [39:0] addr, input logic [2:0] size,
                           input int nb, input bit bp, input int abort_at, input bit nolast);
        logic [HW-1:0] orig;
        logic [2:0] sub_sz;
        int hdrs_up, beats_up, up_dhs, n;
        bit hdone, ddone;
        orig    = mk_hdr(wr, addr, size);
        sub_sz  = (size > 3'd3) ? 3'd3 : size;
        hdrs_up = 0;
        beats_up = 0;
        up_dhs  = 0;
        mem_cmd_header_i   = orig;
        mem_cmd_has_data_i = wr;
        mem_cmd_header_v_i = 1'b1;
        #1;
        check("up_hdr_ready", 64'(mem_cmd_header_ready_and_o), 64'd1);
        tick();
        mem_cmd_header_v_i = 1'b0;
        for (int j = 0; j < nb; j++) begin
            if (wr) begin
                mem_cmd_data_i      = 64'h1111 * j;
                mem_cmd_data_last_i = (j == nb - 1);
                mem_cmd_data_v_i    = 1'b1;
            end
            #1;
            if (j == abort_at) begin
                check("pre_rst_cmd_v", 64'(mem_cmd_header_v_o), 64'd1);
                reset_i = 1'b0;
                #1;
                check("rst_valids", 64'({mem_cmd_header_v_o, mem_cmd_data_v_o, mem_cmd_header_ready_and_o,
                                         mem_cmd_data_ready_and_o, mem_resp_header_v_o, mem_resp_data_v_o}), 64'd0);
                mem_cmd_data_v_i = 1'b0;
                tick();
                reset_i = 1'b1;
                #1;
                return;
            end
            if (j == 0) check("first_cmd_latency", 64'(mem_cmd_header_v_o), 64'd1);
            hdone = 0;
            ddone = !wr;
            n = 0;
            while (!(hdone && ddone) && n < 40) begin
                mem_cmd_header_ready_and_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_cmd_data_ready_and_i   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (mem_cmd_data_v_i && mem_cmd_data_ready_and_o) up_dhs++;
                if (mem_cmd_header_v_o && mem_cmd_header_ready_and_i) begin
                    check("cmd_hdr_once", 64'(hdone), 64'd0);
                    check("sub_hdr", 64'(mem_cmd_header_o), 64'(mk_hdr(wr, exp_a[j], sub_sz)));
                    check("sub_has_data", 64'(mem_cmd_has_data_o), 64'(wr));
                    hdone = 1;
                end
                if (mem_cmd_data_v_o && mem_cmd_data_ready_and_i) begin
                    check("cmd_data_once", 64'(ddone), 64'd0);
                    check("sub_data", mem_cmd_data_o, 64'h1111 * j);
                    check("sub_last", 64'(mem_cmd_data_last_o), 64'd1);
                    ddone = 1;
                end
                tick();
                n++;
            end
            check("cmd_timeout", 64'(hdone && ddone), 64'd1);
            mem_cmd_data_v_i = 1'b0;
            mem_cmd_header_ready_and_i = 1'b0;
            mem_cmd_data_ready_and_i   = 1'b0;

            mem_resp_header_i    = mk_hdr(wr, exp_a[j], sub_sz);
            mem_resp_has_data_i  = !wr;
            mem_resp_header_v_i  = 1'b1;
            mem_resp_data_i      = 64'hDA7A_0000_0000_0000 | 64'(j);
            mem_resp_data_v_i    = !wr;
            mem_resp_data_last_i = !(nolast && j == 0);
            hdone = 0;
            ddone = wr;
            n = 0;
            while (!(hdone && ddone) && n < 40) begin
                mem_resp_header_ready_and_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_resp_data_ready_and_i   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (mem_resp_header_v_o && mem_resp_header_ready_and_i) begin
                    hdrs_up++;
                    check("up_resp_hdr", 64'(mem_resp_header_o), 64'(orig));
                    check("up_resp_has_data", 64'(mem_resp_has_data_o), 64'(!wr));
                end
                if (mem_resp_data_v_o && mem_resp_data_ready_and_i) begin
                    beats_up++;
                    check("up_resp_data", mem_resp_data_o, 64'hDA7A_0000_0000_0000 | 64'(j));
                    check("up_resp_last", 64'(mem_resp_data_last_o), 64'(j == nb - 1));
                end
                if (mem_resp_header_v_i && mem_resp_header_ready_and_o) hdone = 1;
                if (mem_resp_data_v_i && mem_resp_data_ready_and_o) ddone = 1;
                tick();
                n++;
                if (hdone) mem_resp_header_v_i = 1'b0;
                if (ddone) mem_resp_data_v_i = 1'b0;
            end
            check("resp_timeout", 64'(hdone && ddone), 64'd1);
            mem_resp_header_v_i = 1'b0;
            mem_resp_data_v_i   = 1'b0;
            mem_resp_header_ready_and_i = 1'b0;
            mem_resp_data_ready_and_i   = 1'b0;
        end
        check("up_hdr_count", 64'(hdrs_up), 64'd1);
        check("up_beat_count", 64'(beats_up), wr ? 64'd0 : 64'(nb));
        check("up_data_pops", 64'(up_dhs), wr ? 64'(nb) : 64'd0);
        #1;
        check("idle_after", 64'(mem_cmd_header_ready_and_o), 64'd1);
    endtask

    initial begin
`ifdef BP_ME_BEAT_SPLITTER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset_i = 1'b0;
        mem_cmd_header_i = '0; mem_cmd_header_v_i = 1'b0; mem_cmd_has_data_i = 1'b0;
        mem_cmd_data_i = '0; mem_cmd_data_v_i = 1'b0; mem_cmd_data_last_i = 1'b0;
        mem_cmd_header_ready_and_i = 1'b0; mem_cmd_data_ready_and_i = 1'b0;
        mem_resp_header_i = '0; mem_resp_header_v_i = 1'b0; mem_resp_has_data_i = 1'b0;
        mem_resp_data_i = '0; mem_resp_data_v_i = 1'b0; mem_resp_data_last_i = 1'b0;
        mem_resp_header_ready_and_i = 1'b0; mem_resp_data_ready_and_i = 1'b0;

        tick();
        mem_cmd_header_v_i = 1'b1;
        #1;
        check("rst_hdr_ready", 64'(mem_cmd_header_ready_and_o), 64'd0);
        check("rst_cmd_v", 64'(mem_cmd_header_v_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        mem_cmd_header_v_i = 1'b0;
        reset_i = 1'b1;
        #1;
        check("idle_ready", 64'(mem_cmd_header_ready_and_o), 64'd1);
        tick();

        // 64B read, wrapping from offset 0x10
        exp_a = '{40'h8000_0010, 40'h8000_0018, 40'h8000_0020, 40'h8000_0028,
                  40'h8000_0030, 40'h8000_0038, 40'h8000_0000, 40'h8000_0008};
        run_txn(1'b0, 40'h8000_0010, 3'd6, 8, 1'b0, -1, 1'b0);

        // 64B write
        exp_a = '{40'h8000_0000, 40'h8000_0008, 40'h8000_0010, 40'h8000_0018,
                  40'h8000_0020, 40'h8000_0028, 40'h8000_0030, 40'h8000_0038};
        run_txn(1'b1, 40'h8000_0000, 3'd6, 8, 1'b0, -1, 1'b0);

        // 4B read passes through as one beat
        exp_a[0] = 40'h0010_0008;
        run_txn(1'b0, 40'h0010_0008, 3'd2, 1, 1'b0, -1, 1'b0);

        // 128B read clamps to 8 beats within the aligned 64B block
        exp_a = '{40'h3000_0040, 40'h3000_0048, 40'h3000_0050, 40'h3000_0058,
                  40'h3000_0060, 40'h3000_0068, 40'h3000_0070, 40'h3000_0078};
        run_txn(1'b0, 40'h3000_0040, 3'd7, 8, 1'b0, -1, 1'b0);

        // 64B read under random backpressure
        exp_a = '{40'h1000_0038, 40'h1000_0000, 40'h1000_0008, 40'h1000_0010,
                  40'h1000_0018, 40'h1000_0020, 40'h1000_0028, 40'h1000_0030};
        run_txn(1'b0, 40'h1000_0038, 3'd6, 8, 1'b1, -1, 1'b0);

        // Reset in the middle of a 64B write, then a normal transaction
        exp_a = '{40'h8000_0000, 40'h8000_0008, 40'h8000_0010, 40'h8000_0018,
                  40'h8000_0020, 40'h8000_0028, 40'h8000_0030, 40'h8000_0038};
        run_txn(1'b1, 40'h8000_0000, 3'd6, 8, 1'b0, 3, 1'b0);
        check("idle_after_rst", 64'(mem_cmd_header_ready_and_o), 64'd1);
        check("no_cmd_after_rst", 64'(mem_cmd_header_v_o), 64'd0);
        tick();
        exp_a[0] = 40'h0010_0008;
        run_txn(1'b0, 40'h0010_0008, 3'd2, 1, 1'b0, -1, 1'b0);
        check("err_clean", 64'(err_o), 64'd0);

        // Host beat without last
        exp_a[0] = 40'h2000_0008;
        run_txn(1'b0, 40'h2000_0008, 3'd3, 1, 1'b0, -1, 1'b1);
        check("err_set", 64'(err_o), 64'(exp_err));
        tick(); tick(); tick();
        check("err_sticky", 64'(err_o), 64'(exp_err));
        reset_i = 1'b0;
        #1;
        check("err_cleared", 64'(err_o), 64'd0);
        reset_i = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
